// File: rtl/clk_period_meter.sv
// clk_period_meter: synchronizes a slow clock/toggle, ticks on its rising edges,
// measures its period in clk cycles, and flags loss of signal. Option: PERIOD_METER_HIGH_TIME_EN.
module clk_period_meter #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 100000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             slow_in,
  output logic             edge_tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
`ifdef PERIOD_METER_HIGH_TIME_EN
  ,
  output logic [CNT_W-1:0] high_time
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] STALE   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   prev_q;
  logic                   rise;
  logic [CNT_W-1:0]       cnt;
  logic [1:0]             state;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_q;

  // synchronizer chain plus previous-value flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_in};
      prev_q <= sync_out;
    end
  end

  // registered one-cycle tick per synchronized rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_tick <= 1'b0;
    else        edge_tick <= rise;
  end

  // interval counter: restarts on each edge, saturates at TIMEOUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (rise)            cnt <= '0;
    else if (cnt != CNT_MAX)  cnt <= cnt + CNT_ONE;
  end

  // lock/timeout state machine; an edge beats a coincident timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) state <= MEASURE;
        end
        MEASURE: begin
          if (rise) begin
            period       <= cnt + CNT_ONE;
            period_valid <= 1'b1;
            locked       <= 1'b1;
          end else if (cnt == CNT_TO) begin
            state   <= STALE;
            timeout <= 1'b1;
            locked  <= 1'b0;
          end
        end
        STALE: begin
          if (rise) begin
            state   <= MEASURE;
            timeout <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PERIOD_METER_HIGH_TIME_EN
  logic [CNT_W-1:0] hcnt;

  // high-phase counter; the rising-edge cycle is itself a high cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            hcnt <= '0;
    else if (rise)                         hcnt <= CNT_ONE;
    else if (sync_out && hcnt != CNT_MAX)  hcnt <= hcnt + CNT_ONE;
  end

  // capture high time on the synchronized falling edge while measuring
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      high_time <= '0;
    else if (!sync_out && prev_q && state == MEASURE)
      high_time <= hcnt;
  end
`endif

endmodule
